// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit carry-lookahead slice is reused WIDTH/4 times, LSB nibble first.
// Define CLA_NIBBLE_SERIAL_OVF_EN to add the signed-overflow output ovf.
module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef CLA_NIBBLE_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg, cout_reg;

  // 4-bit carry-lookahead slice (A, B, Cin -> S, Cout)
  logic [3:0] slice_a, slice_b, slice_s, slice_g, slice_p;
  logic [4:0] slice_c;
  logic       slice_cout;

  assign slice_a = a_reg[3:0];
  assign slice_b = b_reg[3:0];
  assign slice_g = slice_a & slice_b;
  assign slice_p = slice_a ^ slice_b;

  assign slice_c[0] = carry_reg;
  assign slice_c[1] = slice_g[0] | (slice_p[0] & carry_reg);
  assign slice_c[2] = slice_g[1] | (slice_p[1] & slice_g[0]) | (&slice_p[1:0] & carry_reg);
  assign slice_c[3] = slice_g[2] | (slice_p[2] & slice_g[1]) | (&slice_p[2:1] & slice_g[0])
                    | (&slice_p[2:0] & carry_reg);
  assign slice_c[4] = slice_g[3] | (slice_p[3] & slice_g[2]) | (&slice_p[3:2] & slice_g[1])
                    | (&slice_p[3:1] & slice_g[0]) | (&slice_p[3:0] & carry_reg);
  assign slice_cout = slice_c[4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_sum_bit
    assign slice_s[gi] = slice_p[gi] ^ slice_c[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_reg == LAST) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef CLA_NIBBLE_SERIAL_OVF_EN
  logic ovf_reg;
  // Carry into the word MSB is the slice's internal bit-3 carry on the last nibble.
  always_ff @(posedge clk) begin
    if (rst)                                      ovf_reg <= 1'b0;
    else if (state_reg == RUN && cnt_reg == LAST) ovf_reg <= slice_c[3] ^ slice_cout;
  end
  assign ovf = ovf_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            sum_reg   <= '0;
            carry_reg <= cin;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          sum_reg[4*int'(cnt_reg) +: 4] <= slice_s;
          carry_reg <= slice_cout;
          a_reg     <= a_reg >> 4;
          b_reg     <= b_reg >> 4;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) cout_reg <= slice_cout;
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Directed and random checks of cla_nibble_serial_adder at WIDTH=16 and WIDTH=8.
`timescale 1ns/1ps
module tb_cla_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid16 = 1'b0, in_ready16, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        out_valid16, out_ready16 = 1'b0, cout16, busy16;
  logic        in_valid8 = 1'b0, in_ready8, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        out_valid8, out_ready8 = 1'b0, cout8, busy8;
`ifdef CLA_NIBBLE_SERIAL_OVF_EN
  logic        ovf16, ovf8;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cla_nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .busy(busy16)
`ifdef CLA_NIBBLE_SERIAL_OVF_EN
    , .ovf(ovf16)
`endif
  );

  cla_nibble_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .busy(busy8)
`ifdef CLA_NIBBLE_SERIAL_OVF_EN
    , .ovf(ovf8)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with dut16 idle; returns at a negedge one cycle after the output handshake.
  task automatic do_op16(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    a16 = ta; b16 = tb; cin16 = tc; in_valid16 = 1'b1; out_ready16 = 1'b1;
    check({tag, "_in_ready"}, in_ready16, 1);
    @(posedge clk); @(negedge clk);
    in_valid16 = 1'b0;
    a16 = ~ta; b16 = ~tb; cin16 = ~tc;
    lat = 0;
    while (!out_valid16 && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, sum16, es);
    check({tag, "_cout"}, cout16, ec);
`ifdef CLA_NIBBLE_SERIAL_OVF_EN
    check({tag, "_ovf"}, ovf16, eo);
`else
    if (eo === 1'bx) check({tag, "_ovf_arg"}, eo, 0);
`endif
    @(posedge clk); @(negedge clk);
    check({tag, "_out_valid_drop"}, out_valid16, 0);
    check({tag, "_in_ready_back"}, in_ready16, 1);
    $display("op16 %s a=%h b=%h cin=%0d sum=%h cout=%0d", tag, ta, tb, tc, sum16, cout16);
  endtask

  task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    int lat;
    logic [8:0] exp;
    exp = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
    a8 = ta; b8 = tb; cin8 = tc; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check("op8_latency", lat, 2);
    check("op8_result", {cout8, sum8}, exp);
`ifdef CLA_NIBBLE_SERIAL_OVF_EN
    check("op8_ovf", ovf8, (ta[7] == tb[7]) && (exp[7] != ta[7]));
`endif
    $display("op8 a=%h b=%h cin=%0d sum=%h cout=%0d", ta, tb, tc, sum8, cout8);
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] rexp;
    logic [15:0] held_sum;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready16, 1);
    check("rst_out_valid", out_valid16, 0);
    check("rst_busy", busy16, 0);
    check("rst_sum", sum16, 0);
    check("rst_cout", cout16, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op16("carry_nibble", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op16("ripple_all", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op16("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // Backpressure: result held 4 cycles, extra in_valid ignored
    a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b1; in_valid16 = 1'b1; out_ready16 = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid16 = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    check("bp_valid", out_valid16, 1);
    a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0; in_valid16 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_sum", sum16, 16'h5556);
      check("bp_cout", cout16, 0);
      check("bp_in_ready", in_ready16, 0);
      check("bp_valid_hold", out_valid16, 1);
      if (i < 3) begin @(posedge clk); @(negedge clk); end
    end
    in_valid16 = 1'b0; out_ready16 = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp_in_ready_after", in_ready16, 1);
    check("bp_busy_after", busy16, 0);
    $display("backpressure sum=%h cout=%0d", sum16, cout16);

    // Reset mid-RUN discards the partial result
    a16 = 16'hABCD; b16 = 16'h1111; cin16 = 1'b0; in_valid16 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid16 = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check("mid_busy", busy16, 1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out_valid", out_valid16, 0);
    check("mid_rst_busy", busy16, 0);
    check("mid_rst_sum", sum16, 0);
    check("mid_rst_in_ready", in_ready16, 1);
    $display("mid-run reset sum=%h busy=%0d", sum16, busy16);
    do_op16("after_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    do_op16("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op16("ovf_neg", 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    do_op16("no_ovf", 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0);

    held_sum = 16'h0;
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      rexp = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      do_op16("rand16", ra, rb, rc, rexp[15:0], rexp[16],
              (ra[15] == rb[15]) && (rexp[15] != ra[15]));
      held_sum = held_sum ^ rexp[15:0];
    end
    for (int n = 0; n < 1000; n++) begin
      do_op8(8'($urandom), 8'($urandom), 1'($urandom));
    end
    do_op8(8'hFF, 8'hFF, 1'b1);
    do_op8(8'h00, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
